// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with a DEPTH-entry circular buffer, flush and bubble output.
// Optional PIPE_STAGE_READY_BYPASS_EN lets a full stage accept a beat in the same cycle it pops.
module pipe_stage_elastic #(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH       = 2,
  parameter logic [31:0] NOP_PAYLOAD = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [2**PW];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic alive_q, full, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full = cnt_q == CW'(DEPTH);
  // alive_q keeps the stage closed while reset is held and for the edge that releases it
`ifdef PIPE_STAGE_READY_BYPASS_EN
  assign in_ready_o = alive_q & (!full | out_ready_i | flush_i);
`else
  assign in_ready_o = alive_q & (!full | flush_i);
`endif
  assign out_valid_o = cnt_q != '0;
  assign out_data_o  = out_valid_o ? mem_q[rd_q] : WIDTH'(NOP_PAYLOAD);
  assign count_o     = cnt_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  always_comb begin
    rd_d  = flush_i ? '0 : pop ? nxt(rd_q) : rd_q;
    wr_d  = flush_i ? '0 : push ? nxt(wr_q) : wr_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
    end
  end
  // a full-stage push under bypass lands in the slot the simultaneous pop frees (wr_q == rd_q)
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_q] <= in_data_i;
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed vector table plus hand sequences for reset, flush, wrap and DEPTH=1 throughput.
module tb_pipe_stage_elastic;
`ifdef PIPE_STAGE_READY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, iv = 1'b0, ordy = 1'b0, fl = 1'b0;
  logic [31:0] din = '0;
  logic ir1, ir2, ir3, ov1, ov2, ov3;
  logic [31:0] od1, od2, od3;
  logic c1;
  logic [1:0] c2, c3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_elastic #(.DEPTH(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv), .in_ready_o(ir1),
    .in_data_i(din), .out_valid_o(ov1), .out_ready_i(ordy), .out_data_o(od1), .flush_i(fl), .count_o(c1));
  pipe_stage_elastic #(.DEPTH(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv), .in_ready_o(ir2),
    .in_data_i(din), .out_valid_o(ov2), .out_ready_i(ordy), .out_data_o(od2), .flush_i(fl), .count_o(c2));
  pipe_stage_elastic #(.DEPTH(3)) u3 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv), .in_ready_o(ir3),
    .in_data_i(din), .out_valid_o(ov3), .out_ready_i(ordy), .out_data_o(od3), .flush_i(fl), .count_o(c3));
  typedef struct {
    logic iv; logic [31:0] d; logic ordy; logic fl;
    logic ov; logic [31:0] od; int cnt; logic ir;
  } vec_t;
  vec_t tv[18];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic flush_all();
    @(negedge clk);
    iv = 1'b0; ordy = 1'b0; fl = 1'b1;
    @(negedge clk);
    fl = 1'b0;
  endtask
  task automatic stream(input int depth, input int n, input bit rnd, input logic [31:0] base);
    logic [31:0] q[$];
    int sent = 0, rx = 0, it = 0, cx;
    logic ovx, irx, eir;
    logic [31:0] odx;
    while (rx < n && it < 200) begin
      @(negedge clk);
      iv = sent < n; din = base + 32'(sent); fl = 1'b0;
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (depth == 1) begin ovx = ov1; odx = od1; irx = ir1; cx = int'(c1); end
      else if (depth == 3) begin ovx = ov3; odx = od3; irx = ir3; cx = int'(c3); end
      else begin ovx = ov2; odx = od2; irx = ir2; cx = int'(c2); end
      eir = (q.size() < depth) | (BYP & ordy);
      chk("stream_ready", irx, eir);
      chk("stream_valid", ovx, q.size() != 0);
      chk("stream_count", cx, q.size());
      if (q.size() != 0) chk("stream_data", odx, q[0]);
      if (q.size() != 0 && ordy) begin void'(q.pop_front()); rx++; end
      if (iv && eir) begin q.push_back(din); sent++; end
      it++;
    end
    chk("stream_beats", rx, n);
    if (!rnd) chk("stream_cycles", it, (depth == 1 && !BYP) ? 2 * n : n + 1);
    iv = 1'b0; ordy = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1, 32'hA1, 1, 0, 0, 32'h13, 0, 1};
    tv[1]  = '{1, 32'hA2, 1, 0, 1, 32'hA1, 1, 1};
    tv[2]  = '{1, 32'hA3, 1, 0, 1, 32'hA2, 1, 1};
    tv[3]  = '{1, 32'hA4, 1, 0, 1, 32'hA3, 1, 1};
    tv[4]  = '{0, 32'h00, 1, 0, 1, 32'hA4, 1, 1};
    tv[5]  = '{0, 32'h00, 1, 0, 0, 32'h13, 0, 1};
    tv[6]  = '{1, 32'hB1, 0, 0, 0, 32'h13, 0, 1};
    tv[7]  = '{1, 32'hB2, 0, 0, 1, 32'hB1, 1, 1};
    tv[8]  = '{1, 32'hB3, 0, 0, 1, 32'hB1, 2, 0};
    tv[9]  = '{0, 32'hB3, 1, 0, 1, 32'hB1, 2, BYP};
    tv[10] = '{1, 32'hB3, 1, 0, 1, 32'hB2, 1, 1};
    tv[11] = '{0, 32'h00, 1, 0, 1, 32'hB3, 1, 1};
    tv[12] = '{0, 32'h00, 0, 0, 0, 32'h13, 0, 1};
    tv[13] = '{1, 32'hD1, 0, 0, 0, 32'h13, 0, 1};
    tv[14] = '{1, 32'hD2, 0, 0, 1, 32'hD1, 1, 1};
    tv[15] = '{1, 32'hC1, 1, 1, 1, 32'hD1, 2, 1};
    tv[16] = '{0, 32'h00, 1, 0, 0, 32'h13, 0, 1};
    tv[17] = '{0, 32'h00, 1, 0, 0, 32'h13, 0, 1};
    #2;
    chk("rst_valid", ov2, 0);
    chk("rst_data", od2, 32'h13);
    chk("rst_count", c2, 0);
    chk("rst_ready", ir2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", ir2, 1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      iv = tv[i].iv; din = tv[i].d; ordy = tv[i].ordy; fl = tv[i].fl;
      #1;
      chk($sformatf("vec%0d_valid", i), ov2, tv[i].ov);
      chk($sformatf("vec%0d_data", i), od2, tv[i].od);
      chk($sformatf("vec%0d_count", i), c2, tv[i].cnt);
      chk($sformatf("vec%0d_ready", i), ir2, tv[i].ir);
    end
    @(negedge clk);
    iv = 1'b1; din = 32'h55; ordy = 1'b0; fl = 1'b0;
    @(negedge clk);
    din = 32'h66;
    @(negedge clk);
    iv = 1'b0;
    #1;
    chk("pre_rst_count", c2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov2, 0);
    chk("async_rst_data", od2, 32'h13);
    chk("async_rst_count", c2, 0);
    chk("async_rst_ready", ir2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rerelease_ready", ir2, 1);
    chk("rerelease_valid", ov2, 0);
    flush_all();
    stream(2, 4, 1'b0, 32'hA1);
    flush_all();
    stream(3, 10, 1'b1, 32'h00);
    flush_all();
    stream(1, 4, 1'b0, 32'hE1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
